// File: rtl/boot_pkg.sv
// boot_pkg: shared state encoding and stream framing constants for boot_loader.
// BOOT_LOADER_CHECKSUM_EN adds the CHECK state.
package boot_pkg;
   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;
`ifdef BOOT_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_LOAD, S_CHECK, S_DONE, S_RUN, S_ERROR} state_t;
`else
   typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_LOAD, S_DONE, S_RUN, S_ERROR} state_t;
`endif
endpackage

// File: rtl/word_packer.sv
// word_packer: shifts accepted bytes MSB-first and flags the byte that completes a word.
module word_packer
   import boot_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   input  logic [7:0]  i_byte,
   output logic        o_word_valid,
   output logic [31:0] o_word
);
   logic [8*(WORD_BYTES-1)-1:0]   r_shift;
   logic [$clog2(WORD_BYTES)-1:0] r_idx;
   // Word is presented combinationally with its last byte so the top can register the write.
   assign o_word_valid = i_valid && r_idx == $clog2(WORD_BYTES)'(WORD_BYTES-1);
   assign o_word       = {r_shift, i_byte};
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift <= '0;
         r_idx   <= '0;
      end else if (i_valid) begin
         r_shift <= {r_shift[8*(WORD_BYTES-2)-1:0], i_byte};
         r_idx   <= r_idx + 1'b1;
      end
   end
endmodule

// File: rtl/boot_loader.sv
// boot_loader: loads a length-prefixed byte image into instruction memory, then releases the CPU.
// BOOT_LOADER_CHECKSUM_EN enables the trailing checksum byte and its CHECK state.
module boot_loader
   import boot_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [7:0]            byte_data_i,
   input  logic                  byte_valid_i,
   output logic                  byte_ready_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   output logic [31:0]           imem_data_o,
   output logic                  imem_we_o,
   output logic                  cpu_rst_o,
   output logic                  done_o,
   output logic                  error_o
);
   localparam int unsigned ROOM = (1 << ADDR_WIDTH) - BASE_ADDR;
`ifdef BOOT_LOADER_CHECKSUM_EN
   localparam state_t S_TAIL = S_CHECK;
   logic [7:0] r_sum;
`else
   localparam state_t S_TAIL = S_DONE;
`endif
   state_t                  r_state, w_state_nxt;
   logic [8*LEN_BYTES-1:0]  r_len;
   logic [ADDR_WIDTH:0]     r_cnt;
   logic [8*LEN_BYTES-1:0]  w_len;
   logic                    w_xfer, w_load, w_word_valid, w_last, w_big, w_rdy_nxt;
   logic [31:0]             w_word;
   assign w_xfer = byte_valid_i && byte_ready_o;
   assign w_load = w_xfer && r_state == S_LOAD;
   assign w_len  = {r_len[8*LEN_BYTES-1:8], byte_data_i};
   assign w_big  = 32'(w_len) > ROOM;
   assign w_last = w_word_valid && 32'(r_cnt + 1'b1) == 32'(r_len);
   word_packer u_packer (
      .i_clk        (clk_i),
      .i_rst_n      (rst_ni),
      .i_valid      (w_load),
      .i_byte       (byte_data_i),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_LEN_HI: w_state_nxt = w_xfer ? S_LEN_LO : r_state;
         S_LEN_LO: w_state_nxt = !w_xfer ? r_state : w_big ? S_ERROR : w_len == '0 ? S_TAIL : S_LOAD;
         S_LOAD:   w_state_nxt = w_last ? S_TAIL : r_state;
`ifdef BOOT_LOADER_CHECKSUM_EN
         S_CHECK:  w_state_nxt = !w_xfer ? r_state : 8'(r_sum + byte_data_i) == 8'd0 ? S_DONE : S_ERROR;
`endif
         S_DONE:   w_state_nxt = S_RUN;
         default:  w_state_nxt = r_state;
      endcase
   end
   // Ready tracks the next state so no byte is ever accepted outside an accepting state.
   assign w_rdy_nxt = w_state_nxt == S_LEN_HI || w_state_nxt == S_LEN_LO || w_state_nxt == S_LOAD
`ifdef BOOT_LOADER_CHECKSUM_EN
      || w_state_nxt == S_CHECK
`endif
      ;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= S_LEN_HI;
         r_len        <= '0;
         r_cnt        <= '0;
         byte_ready_o <= 1'b0;
         imem_we_o    <= 1'b0;
         imem_addr_o  <= '0;
         imem_data_o  <= '0;
         cpu_rst_o    <= 1'b1;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
         r_sum        <= '0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         byte_ready_o <= w_rdy_nxt;
         cpu_rst_o    <= r_state != S_RUN;
         done_o       <= r_state == S_RUN;
         error_o      <= r_state == S_ERROR;
         imem_we_o    <= w_word_valid;
         if (w_xfer && r_state == S_LEN_HI) r_len[8*LEN_BYTES-1:8] <= byte_data_i;
         if (w_xfer && r_state == S_LEN_LO) r_len <= w_len;
         if (w_word_valid) begin
            imem_addr_o <= ADDR_WIDTH'(BASE_ADDR) + r_cnt[ADDR_WIDTH-1:0];
            imem_data_o <= w_word;
            r_cnt       <= r_cnt + 1'b1;
         end
`ifdef BOOT_LOADER_CHECKSUM_EN
         if (w_load) r_sum <= r_sum + byte_data_i;
`endif
      end
   end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized stream bench for boot_loader against a list-of-writes reference model.
// Follows BOOT_LOADER_CHECKSUM_EN to decide whether a checksum byte is streamed.
module tb_boot_loader;
   localparam int AW   = 4;
   localparam int BASE = 2;
   localparam int ROOM = (1 << AW) - BASE;
   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic [7:0]    byte_data = '0;
   logic          byte_valid = 1'b0;
   logic          byte_ready, imem_we, cpu_rst, done, error;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_data;
   always #5 clk = ~clk;
   boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .byte_data_i  (byte_data),
      .byte_valid_i (byte_valid),
      .byte_ready_o (byte_ready),
      .imem_addr_o  (imem_addr),
      .imem_data_o  (imem_data),
      .imem_we_o    (imem_we),
      .cpu_rst_o    (cpu_rst),
      .done_o       (done),
      .error_o      (error)
   );
   int total = 0;
   int bad = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   int              cyc = 0;
   logic [AW+31:0]  got_q[$];
   int              last_we = -1, first_done = -1, prev_we = -100;
   bit              spacing_bad = 0;
   logic [31:0]     words[$];
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (imem_we) begin
         got_q.push_back({imem_addr, imem_data});
         if (cyc - prev_we < 4) spacing_bad = 1;
         prev_we = cyc;
         last_we = cyc;
      end
      if (done && first_done < 0) first_done = cyc;
   end
   task automatic do_reset();
      @(negedge clk);
      rst_ni = 1'b0;
      byte_valid = 1'b0;
      #1;
      check("rst_ready", byte_ready, 0);
      check("rst_we", imem_we, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_data", imem_data, 0);
      check("rst_cpu_rst", cpu_rst, 1);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      repeat (2) @(negedge clk);
      got_q.delete();
      last_we = -1;
      first_done = -1;
      prev_we = -100;
      spacing_bad = 0;
      rst_ni = 1'b1;
      @(negedge clk);
      check("ready_rise", byte_ready, 1);
   endtask
   // mode 0: full rate, 1: valid every other cycle, 2: random gaps
   task automatic send_byte(input logic [7:0] b, input int mode);
      int k = 0;
      int gap = mode == 0 ? 0 : mode == 1 ? 1 : int'($urandom_range(0, 3));
      @(negedge clk);
      repeat (gap) begin
         byte_valid = 1'b0;
         @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data = b;
      while (!byte_ready && k < 50) begin
         k++;
         @(negedge clk);
      end
      if (k >= 50) begin
         check("ready_timeout", 0, 1);
         byte_valid = 1'b0;
      end else @(posedge clk);
   endtask
   task automatic run(input int n, input int mode, input int cks_adj, input string tag);
      logic [7:0]    sum = '0;
      logic [AW+31:0] e;
      bit            hdr_err = n > ROOM;
      bit            exp_err = hdr_err;
      int            k = 0;
      int            n_exp;
      send_byte(8'(n >> 8), mode);
      send_byte(8'(n), mode);
      if (!hdr_err) begin
         foreach (words[i]) for (int j = 3; j >= 0; j--) begin
            send_byte(words[i][8*j +: 8], mode);
            sum += words[i][8*j +: 8];
         end
`ifdef BOOT_LOADER_CHECKSUM_EN
         send_byte(8'(0 - sum + cks_adj), mode);
         exp_err = cks_adj != 0;
`endif
      end
      @(negedge clk);
      byte_valid = 1'b0;
      while (!done && !error && k < 30) begin
         k++;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      check({tag, " done"}, done, !exp_err);
      check({tag, " error"}, error, exp_err);
      check({tag, " cpu_rst"}, cpu_rst, exp_err);
      check({tag, " ready"}, byte_ready, 0);
      n_exp = hdr_err ? 0 : words.size();
      check({tag, " nwrites"}, got_q.size(), n_exp);
      for (int i = 0; i < n_exp && i < got_q.size(); i++) begin
         e = {AW'(BASE + i), words[i]};
         check({tag, " write"}, got_q[i], e);
      end
      check({tag, " spacing"}, spacing_bad, 0);
`ifndef BOOT_LOADER_CHECKSUM_EN
      if (!exp_err && n > 0) check({tag, " release_lat"}, first_done - last_we, 2);
`endif
   endtask
   initial begin
      int n;
      do_reset();
      words = '{32'h3C081234, 32'hAC080000};
      run(2, 0, 0, "full_rate");
      do_reset();
      run(2, 1, 0, "alt_valid");
      do_reset();
      run(17, 0, 0, "oversize17");
      do_reset();
      run(ROOM + 1, 2, 0, "oversize_edge");
      do_reset();
      words.delete();
      for (int i = 0; i < ROOM; i++) words.push_back($urandom);
      run(ROOM, 0, 0, "fill_edge");
`ifdef BOOT_LOADER_CHECKSUM_EN
      do_reset();
      words = '{32'h01020304};
      run(1, 0, 0, "cks_good");
      do_reset();
      run(1, 0, -1, "cks_bad");
`endif
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hDE, 0);
      send_byte(8'hAD, 0);
      check("midload_nowrite", got_q.size(), 0);
      do_reset();
      words = '{32'hDEADBEEF};
      run(1, 0, 0, "after_reset");
      do_reset();
      words.delete();
      run(0, 0, 0, "empty");
      for (int t = 0; t < 8; t++) begin
         do_reset();
         n = $urandom_range(0, ROOM + 2);
         words.delete();
         if (n <= ROOM) for (int i = 0; i < n; i++) words.push_back($urandom);
         run(n, 2, 0, "random");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
